seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial pattern detector; successor to the fixed 4-bit Moore detector.
//  Detects a runtime-loadable PAT_W-bit pattern, MSB received first, on a 1-bit stream with valid qualifier.
//  Selectable overlapping / non-overlapping detection; registered one-cycle match pulse.
//  Sits after a serial receiver front-end, feeding framing/sync logic.
// PARAMETERS
//  PAT_W    4        pattern length in bits, >= 2
//  DEF_PAT  4'b1011  pattern loaded at reset, PAT_W bits
//  CNT_W    8        width of match counter, used only with SEQ_MATCH_COUNT_EN
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  in         in   1      serial data bit
//  in_valid   in   1      in sampled only when 1
//  overlap    in   1      1 = overlapping detection, 0 = non-overlapping
//  pat_load   in   1      load pat_in on this edge
//  pat_in     in   PAT_W  new pattern; MSB is the first bit received
//  out        out  1      match pulse, Moore, registered
//  fill       out  $clog2(PAT_W+1)  valid bits currently held in history (0..PAT_W)
//  match_cnt  out  CNT_W  saturating match count, only with SEQ_MATCH_COUNT_EN
// BEHAVIOUR
//  Reset (rst=0, async): pattern=DEF_PAT, history=0, fill=0, out=0, match_cnt=0, state=FILL.
//  Datapath:
//   - history is a PAT_W-bit shift register; on in_valid, hist <= {hist[PAT_W-2:0], in}.
//   - fill increments per valid bit and saturates at PAT_W.
//  States:
//   - FILL:   fill < PAT_W.
//   - DETECT: fill == PAT_W.
//   - FILL -> DETECT on the valid bit that makes fill == PAT_W.
//  Match:
//   - Occurs on a valid bit when the new history == pattern and the new fill == PAT_W.
//   - out=1 for exactly the one cycle after that edge, then 0. in_valid=0 -> out=0 next cycle.
//  Latency: final pattern bit sampled at edge N -> out high during cycle N..N+1.
//  Overlap handling on a match:
//   - overlap=1: history and fill are kept, so shared suffix/prefix bits count toward the next match.
//   - overlap=0: fill <= 0 and state <= FILL, so the next match needs PAT_W fresh bits.
//   - overlap is sampled each edge; changing it mid-stream affects only subsequent matches.
//  pat_load:
//   - pattern <= pat_in; history and fill cleared; out=0 next cycle.
//   - Has priority over a simultaneous in_valid bit; that bit is discarded.
//  Reset mid-stream: all progress lost; pattern returns to DEF_PAT.
//  No X propagation: in is ignored while in_valid=0.
// CONFIGURATION
//  Macro SEQ_MATCH_COUNT_EN:
//   - Defined: match_cnt increments on every out pulse and saturates at 2^CNT_W-1.
//     Cleared by reset and by pat_load.
//   - Undefined: counter logic is removed and match_cnt is tied to 0. Port is always present.
// STRUCTURE
//  Package seq_detect_pkg: state enum {FILL, DETECT}, default pattern constant, fill width function.
//  Sub-module seq_match_counter: saturating CNT_W counter with inc/clr, instantiated only under the macro.
//  Top holds the history shift register, fill counter, compare and output register.
// TESTING
//  1 PAT_W=4, pattern 1011, overlap=1, stream 1011011 all valid -> out pulses after bits 4 and 7; match_cnt=2.
//  2 Same stream, overlap=0 -> single pulse after bit 4; fill=3 at end; match_cnt=1.
//  3 Stream 1,0,(valid=0 x3),1,1 -> one pulse after the last valid bit; out stays 0 during gaps.
//  4 pat_load with pat_in=0110 together with in_valid=1 -> bit dropped and fill=0;
//    then 0110 -> one pulse; 1011 -> no pulse.
//  5 rst low after 3 bits of 1011, release, then 1 -> no pulse; full 1011 after -> pulse.
//  6 CNT_W=2 with SEQ_MATCH_COUNT_EN, 5 matches -> match_cnt saturates at 3;
//    without the macro -> match_cnt stays 0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
// Holds the detector state enum, the reset-default pattern and the fill-width helper.
package seq_detect_pkg;

   typedef enum logic {
      FILL   = 1'b0,
      DETECT = 1'b1
   } state_t;

   localparam logic [3:0] SEQ_DEF_PAT = 4'b1011;

   function automatic int fill_width(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter: counts inc pulses, sticks at all-ones, clr has priority.
// Latency: count updates on the edge after inc; no backpressure.
module seq_match_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector for a runtime-loadable PAT_W-bit pattern (MSB first), overlap selectable.
// Match pulse registered one cycle after the final bit; SEQ_MATCH_COUNT_EN adds a saturating match counter.
module seq_detector_param
   import seq_detect_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT),
   parameter int               CNT_W   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in,
   input  logic                          in_valid,
   input  logic                          overlap,
   input  logic                          pat_load,
   input  logic [PAT_W-1:0]              pat_in,
   output logic                          out,
   output logic [fill_width(PAT_W)-1:0]  fill,
   output logic [CNT_W-1:0]              match_cnt
);

   localparam int                FILL_W = fill_width(PAT_W);
   localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

   state_t              state, state_nxt;
   logic [PAT_W-1:0]    pattern;
   logic [PAT_W-1:0]    hist, hist_nxt;
   logic [FILL_W-1:0]   fill_nxt;
   logic [FILL_W-1:0]   fill_inc;
   logic                match;

   assign fill_inc = fill + 1'b1;

   always_comb begin
      state_nxt = state;
      hist_nxt  = hist;
      fill_nxt  = fill;
      match     = 1'b0;
      if (pat_load) begin
         state_nxt = FILL;
         hist_nxt  = '0;
         fill_nxt  = '0;
      end else if (in_valid) begin
         hist_nxt = {hist[PAT_W-2:0], in};
         case (state)
            FILL: begin
               fill_nxt  = fill_inc;
               state_nxt = (fill_inc == FULL) ? DETECT : FILL;
            end
            DETECT: fill_nxt = FULL;
            default: begin
               fill_nxt  = '0;
               state_nxt = FILL;
            end
         endcase
         match = (fill_nxt == FULL) && (hist_nxt == pattern);
         // Non-overlapping mode discards the matched bits so the next match needs a fresh window.
         if (match && !overlap) begin
            fill_nxt  = '0;
            state_nxt = FILL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern <= DEF_PAT;
         hist    <= '0;
         fill    <= '0;
         out     <= 1'b0;
      end else begin
         if (pat_load) begin
            pattern <= pat_in;
         end
         hist <= hist_nxt;
         fill <= fill_nxt;
         out  <= match;
      end
   end

`ifdef SEQ_MATCH_COUNT_EN
   seq_match_counter #(
      .CNT_W (CNT_W)
   ) u_match_counter (
      .clk (clk),
      .rst (rst),
      .inc (out),
      .clr (pat_load),
      .cnt (match_cnt)
   );
`else
   assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a bit-window reference model pushes per-cycle
// expectations, a monitor pops and compares out/fill/match_cnt one step after each edge.
module tb_seq_detector_param;

   localparam int               PAT_W  = 4;
   localparam int               CNT_W  = 2;
   localparam int               FILL_W = $clog2(PAT_W + 1);
   localparam logic [PAT_W-1:0] DEF    = 4'b1011;

   logic              clk = 1'b0;
   logic              rst;
   logic              in;
   logic              in_valid;
   logic              overlap;
   logic              pat_load;
   logic [PAT_W-1:0]  pat_in;
   logic              out;
   logic [FILL_W-1:0] fill;
   logic [CNT_W-1:0]  match_cnt;

   seq_detector_param #(
      .PAT_W   (PAT_W),
      .DEF_PAT (DEF),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in),
      .in_valid  (in_valid),
      .overlap   (overlap),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .out       (out),
      .fill      (fill),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic o;
      int   f;
      int   c;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: the bits received since the last clear, newest at the back.
   bit               bq[$];
   logic [PAT_W-1:0] m_pat;
   logic             m_out;
   int               m_cnt;

   function automatic int win_val();
      int v = 0;
      foreach (bq[i]) v = v * 2 + int'(bq[i]);
      return v;
   endfunction

   task automatic step(input logic r, input logic v, input logic b, input logic ovl,
                       input logic ld, input logic [PAT_W-1:0] pin);
      exp_t e;
      @(negedge clk);
      rst = r; in_valid = v; in = b; overlap = ovl; pat_load = ld; pat_in = pin;
      if (!r) begin
         m_pat = DEF; bq.delete(); m_out = 1'b0; m_cnt = 0;
      end else begin
         if (ld) m_cnt = 0;
         else if (m_out && m_cnt < (1 << CNT_W) - 1) m_cnt++;
         if (ld) begin
            m_pat = pin; bq.delete(); m_out = 1'b0;
         end else if (v) begin
            bq.push_back(b);
            if (bq.size() > PAT_W) void'(bq.pop_front());
            m_out = (bq.size() == PAT_W) && (win_val() == int'(m_pat));
            if (m_out && !ovl) bq.delete();
         end else begin
            m_out = 1'b0;
         end
      end
      e.o = m_out;
      e.f = bq.size();
`ifdef SEQ_MATCH_COUNT_EN
      e.c = m_cnt;
`else
      e.c = 0;
`endif
      sb.push_back(e);
   endtask

   task automatic send(input logic [15:0] bits, input int n, input logic ovl);
      for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, bits[i], ovl, 1'b0, '0);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'bx, overlap, 1'b0, '0);
   endtask

   // Monitor: checks the DUT one step after each active edge against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (out !== e.o) begin
               n_bad++;
               $display("FAIL out @%0t: got %b expected %b", $time, out, e.o);
            end
            n_cmp++;
            if (fill !== FILL_W'(e.f)) begin
               n_bad++;
               $display("FAIL fill @%0t: got %0d expected %0d", $time, fill, e.f);
            end
            n_cmp++;
            if (match_cnt !== CNT_W'(e.c)) begin
               n_bad++;
               $display("FAIL match_cnt @%0t: got %0d expected %0d", $time, match_cnt, e.c);
            end
         end
      end
   end

   initial begin
      logic ovl_r;
      rst = 1'b0; in = 1'b0; in_valid = 1'b0; overlap = 1'b0; pat_load = 1'b0; pat_in = '0;
      m_pat = DEF; m_out = 1'b0; m_cnt = 0;

      // Reset state, then overlapping detection of 1011011.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      send(16'b1011011, 7, 1'b1);
      gap(2);

      // Same stream, non-overlapping.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
      send(16'b1011011, 7, 1'b0);
      gap(2);

      // Valid gaps with X on the data line.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011);
      send(16'b10, 2, 1'b1);
      gap(3);
      send(16'b11, 2, 1'b1);
      gap(2);

      // pat_load beats a simultaneous valid bit.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
      send(16'b0110, 4, 1'b1);
      send(16'b1011, 4, 1'b1);
      gap(2);

      // Reset mid-stream drops progress and restores the default pattern.
      send(16'b101, 3, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      send(16'b1, 1, 1'b1);
      send(16'b1011, 4, 1'b1);
      gap(2);

      // Five non-overlapping matches drive the 2-bit counter into saturation.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
      for (int k = 0; k < 5; k++) send(16'b1011, 4, 1'b0);
      gap(3);

      // Randomised traffic with occasional loads, resets and overlap changes.
      ovl_r = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(49) == 0) ovl_r = ~ovl_r;
         step(($urandom_range(149) != 0), ($urandom_range(3) != 0), 1'($urandom),
              ovl_r, ($urandom_range(59) == 0), PAT_W'($urandom));
      end

      for (int i = 0; i < 20 && sb.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
